// File: rtl/serial_port_router.sv
// serial_port_router: packs a serial frame bit stream (MSB-first) into WORD_W-bit
// words and delivers them to one of four valid/ready output ports, chosen per frame.
// Compile-time option: define ROUTER_PAD_EN to zero-pad and deliver a trailing
// partial word at frame end; when undefined the partial word is dropped and
// frag_err pulses for one cycle.
module serial_port_router #(
  parameter int WORD_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_in,
  input  logic                  ser_valid,
  input  logic [1:0]            port_sel,
  input  logic [3:0]            out_ready,
  input  logic                  clr_err,
  output logic [4*WORD_W-1:0]   dout,
  output logic [3:0]            out_valid,
  output logic [3:0]            ovf,
  output logic                  frag_err,
  output logic                  busy,
  output logic [7:0]            frame_cnt
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  state_t              state_q;
  // Only WORD_W-1 bits need storing: the last bit of a word is taken straight
  // from ser_in, and a partial word never holds more than WORD_W-1 bits.
  logic [WORD_W-2:0]   shift_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [1:0]          cur_port_q;
  logic                busy_q;
  logic                frag_err_q;
  logic [7:0]          frame_cnt_q;

  logic [WORD_W-1:0]   port_word_q [4];
  logic [3:0]          valid_q;
  logic [3:0]          ovf_q;

  logic [WORD_W-1:0]   shift_ext;
  logic                word_done_d;
  logic                dlv_en_d;
  logic [WORD_W-1:0]   dlv_word_d;
  logic                frag_d;

  // Shifter contents with the current input bit appended at the LSB.
  assign shift_ext = {shift_q, ser_in};

  // Decide whether a word is handed to the current port this cycle.
  always_comb begin
    word_done_d = (state_q == ST_RECV) && ser_valid &&
                  (bit_cnt_q == CNT_W'(WORD_W - 1));
    dlv_en_d    = word_done_d;
    dlv_word_d  = shift_ext;
    frag_d      = 1'b0;
    if ((state_q == ST_CLOSE) && (bit_cnt_q != '0)) begin
`ifdef ROUTER_PAD_EN
      // Received bits sit at positions bit_cnt..1 of {shift_q,0}; moving them
      // up left-aligns them at the MSB, zero-fills the tail and pushes any
      // stale bits from an earlier word out of the top.
      dlv_en_d   = 1'b1;
      dlv_word_d = {shift_q, 1'b0} << (CNT_W'(WORD_W - 1) - bit_cnt_q);
`else
      frag_d     = 1'b1;
`endif
    end
  end

  // Frame FSM: bit collection, frame close, frame counter, busy and frag_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cur_port_q  <= 2'd0;
      busy_q      <= 1'b0;
      frag_err_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      frag_err_q <= frag_d;
      case (state_q)
        ST_IDLE: begin
          if (ser_valid) begin
            cur_port_q <= port_sel;
            shift_q    <= shift_ext[WORD_W-2:0];
            bit_cnt_q  <= CNT_W'(1);
            busy_q     <= 1'b1;
            state_q    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (ser_valid) begin
            shift_q <= shift_ext[WORD_W-2:0];
            if (word_done_d) begin
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else begin
            state_q <= ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          // Any bit offered here is a protocol violation and is ignored.
          bit_cnt_q   <= '0;
          frame_cnt_q <= frame_cnt_q + 8'd1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Per-port output registers: load on delivery, drop and flag overflow when
  // the held word is not being consumed, clear valid when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        port_word_q[p] <= '0;
      end
      valid_q <= 4'd0;
      ovf_q   <= 4'd0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (dlv_en_d && (cur_port_q == 2'(p))) begin
          if (!valid_q[p] || out_ready[p]) begin
            port_word_q[p] <= dlv_word_d;
            valid_q[p]     <= 1'b1;
          end else begin
            ovf_q[p] <= 1'b1;
          end
        end else if (valid_q[p] && out_ready[p]) begin
          valid_q[p] <= 1'b0;
        end
        // A same-cycle overflow beats the clear request.
        if (clr_err && !(dlv_en_d && (cur_port_q == 2'(p)) &&
                         valid_q[p] && !out_ready[p])) begin
          ovf_q[p] <= 1'b0;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_port_out
      assign dout[gi*WORD_W +: WORD_W] = port_word_q[gi];
    end
  endgenerate

  assign out_valid = valid_q;
  assign ovf       = ovf_q;
  assign frag_err  = frag_err_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_port_router.sv
// Self-checking bench for serial_port_router: directed scenarios plus random
// frames, every cycle compared against a frame-level reference model.
module tb_serial_port_router;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           ser_in;
  logic           ser_valid;
  logic [1:0]     port_sel;
  logic [3:0]     out_ready;
  logic           clr_err;
  logic [4*W-1:0] dout;
  logic [3:0]     out_valid;
  logic [3:0]     ovf;
  logic           frag_err;
  logic           busy;
  logic [7:0]     frame_cnt;

  always #5 clk = ~clk;

  serial_port_router #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .port_sel  (port_sel),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .dout      (dout),
    .out_valid (out_valid),
    .ovf       (ovf),
    .frag_err  (frag_err),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame / word level) ----------------
  bit         m_in_frame;
  bit         m_closing;
  logic [1:0] m_port;
  bit         m_bits[$];
  logic [W-1:0] m_dout [4];
  bit [3:0]   m_valid;
  bit [3:0]   m_ovf;
  bit         m_frag;
  bit         m_busy;
  int         m_fcnt;

  // Collected bits, first one at the MSB, unfilled positions zero.
  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w = '0;
    foreach (m_bits[i]) w[W-1-i] = m_bits[i];
    return w;
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_closing = 0; m_port = 0; m_bits.delete();
    for (int p = 0; p < 4; p++) m_dout[p] = '0;
    m_valid = 0; m_ovf = 0; m_frag = 0; m_busy = 0; m_fcnt = 0;
  endtask

  task automatic model_step(input logic sv, input logic si, input logic [1:0] ps,
                            input logic [3:0] rdy, input logic clr);
    bit dlv = 0;
    bit frag_n = 0;
    logic [W-1:0] word = '0;
    if (m_closing) begin
      if (m_bits.size() != 0) begin
`ifdef ROUTER_PAD_EN
        dlv = 1; word = pack_bits();
`else
        frag_n = 1;
`endif
      end
      m_fcnt = (m_fcnt + 1) % 256;
      m_bits.delete();
      m_closing = 0;
    end else if (m_in_frame) begin
      if (sv) begin
        m_bits.push_back(si);
        if (m_bits.size() == W) begin
          dlv = 1; word = pack_bits(); m_bits.delete();
        end
      end else begin
        m_in_frame = 0; m_closing = 1;
      end
    end else if (sv) begin
      m_in_frame = 1; m_port = ps; m_bits.delete(); m_bits.push_back(si);
    end
    for (int p = 0; p < 4; p++) begin
      bit set = 0;
      if (dlv && (int'(m_port) == p)) begin
        if (m_valid[p] && !rdy[p]) set = 1;
        else begin m_dout[p] = word; m_valid[p] = 1; end
      end else if (m_valid[p] && rdy[p]) begin
        m_valid[p] = 0;
      end
      if (set) m_ovf[p] = 1;
      else if (clr) m_ovf[p] = 0;
    end
    m_frag = frag_n;
    m_busy = m_in_frame || m_closing;
  endtask

  task automatic compare_all();
    logic [4*W-1:0] e;
    for (int p = 0; p < 4; p++) e[p*W +: W] = m_dout[p];
    check_val("dout", 64'(dout), 64'(e));
    check_val("out_valid", 64'(out_valid), 64'(m_valid));
    check_val("ovf", 64'(ovf), 64'(m_ovf));
    check_val("frag_err", 64'(frag_err), 64'(m_frag));
    check_val("busy", 64'(busy), 64'(m_busy));
    check_val("frame_cnt", 64'(frame_cnt), 64'(m_fcnt));
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input logic sv, input logic si, input logic [1:0] ps,
                       input logic [3:0] rdy, input logic clr);
    ser_valid = sv; ser_in = si; port_sel = ps; out_ready = rdy; clr_err = clr;
    model_step(sv, si, ps, rdy, clr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_bits(input logic [1:0] port, input logic [31:0] val, input int n,
                           input logic [3:0] rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, val[n-1-i], port, rdy, 1'b0);
  endtask

  task automatic end_frame(input logic [3:0] rdy);
    cycle(1'b0, 1'b0, 2'd0, rdy, 1'b0);
    cycle(1'b0, 1'b0, 2'd0, rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ser_in = 0; ser_valid = 0; port_sel = 0; out_ready = 0; clr_err = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Basic routing to port 2.
    send_bits(2'd2, 32'hB2, 8, 4'hF);
    check_val("t1_word", 64'(dout[23:16]), 64'h B2);
    check_val("t1_valid", 64'(out_valid), 64'h4);
    end_frame(4'hF);
    check_val("t1_cnt", 64'(frame_cnt), 64'd1);
    check_val("t1_pulse", 64'(out_valid), 64'h0);

    // Overflow on port 1 with consumer stalled, then clear and drain.
    send_bits(2'd1, 32'hA53C, 16, 4'h0);
    check_val("t2_hold", 64'(dout[15:8]), 64'hA5);
    check_val("t2_valid", 64'(out_valid[1]), 64'd1);
    check_val("t2_ovf", 64'(ovf[1]), 64'd1);
    end_frame(4'h0);
    cycle(1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
    check_val("t2_clr", 64'(ovf[1]), 64'd0);
    cycle(1'b0, 1'b0, 2'd0, 4'hF, 1'b0);
    check_val("t2_drain", 64'(out_valid[1]), 64'd0);

    // Second word arrives on the same cycle the first is consumed.
    begin
      logic [15:0] v = 16'h1234;
      for (int i = 0; i < 16; i++)
        cycle(1'b1, v[15-i], 2'd0, (i == 15) ? 4'h1 : 4'h0, 1'b0);
    end
    check_val("t3_word", 64'(dout[7:0]), 64'h34);
    check_val("t3_valid", 64'(out_valid[0]), 64'd1);
    check_val("t3_ovf", 64'(ovf[0]), 64'd0);
    end_frame(4'hF);

    // 11-bit frame on port 3: full word then a 3-bit fragment.
    send_bits(2'd3, 32'hFF, 8, 4'hF);
    check_val("t4_word", 64'(dout[31:24]), 64'hFF);
    send_bits(2'd3, 32'h5, 3, 4'hF);
    end_frame(4'h0);
`ifdef ROUTER_PAD_EN
    check_val("t4_pad", 64'(dout[31:24]), 64'hA0);
    check_val("t4_padv", 64'(out_valid[3]), 64'd1);
    check_val("t4_frag", 64'(frag_err), 64'd0);
`else
    check_val("t4_frag", 64'(frag_err), 64'd1);
    check_val("t4_nov", 64'(out_valid[3]), 64'd0);
    check_val("t4_keep", 64'(dout[31:24]), 64'hFF);
`endif
    cycle(1'b0, 1'b0, 2'd0, 4'hF, 1'b0);
    check_val("t4_fragoff", 64'(frag_err), 64'd0);

    // Reset in the middle of a frame.
    send_bits(2'd0, 32'h16, 5, 4'hF);
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    check_val("t5_dout", 64'(dout), 64'd0);
    check_val("t5_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
    send_bits(2'd2, 32'hC3, 8, 4'h0);
    check_val("t5_word", 64'(dout[23:16]), 64'hC3);
    end_frame(4'hF);
    check_val("t5_cnt1", 64'(frame_cnt), 64'd1);

    // 255 more one-word frames: counter wraps to zero.
    for (int f = 0; f < 255; f++)
      begin
        send_bits(2'($urandom), 32'($urandom_range(0, 255)), 8, 4'($urandom));
        end_frame(4'($urandom));
      end
    check_val("t6_wrap", 64'(frame_cnt), 64'd0);

    // Random frames: arbitrary lengths, random ready/clr, CLOSE-cycle violations.
    for (int f = 0; f < 80; f++) begin
      int len = $urandom_range(1, 20);
      logic [1:0] prt = 2'($urandom);
      for (int i = 0; i < len; i++)
        cycle(1'b1, 1'($urandom), (i == 0) ? prt : 2'($urandom), 4'($urandom),
              1'($urandom_range(0, 7) == 0));
      cycle(1'b0, 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom_range(0, 7) == 0));
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom), 4'($urandom), 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        cycle(1'b0, 1'b0, 2'd0, 4'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
